// File: rtl/mem_stage_pkg.sv
// Shared LC-3b data types for the memory-access stage: the machine word,
// the two-lane byte-enable mask and small helpers for lane selection.
package lc3b_types;

   localparam int LC3B_WORD_W = 16;

   typedef logic [LC3B_WORD_W-1:0] lc3b_word;
   typedef logic [1:0]             lc3b_mem_wmask;

   // Byte-lane masks; bit 1 selects the high byte.
   localparam lc3b_mem_wmask WMASK_NONE = 2'b00;
   localparam lc3b_mem_wmask WMASK_LOW  = 2'b01;
   localparam lc3b_mem_wmask WMASK_HIGH = 2'b10;
   localparam lc3b_mem_wmask WMASK_WORD = 2'b11;

   // Lane mask for an access: whole word, or the lane picked by address bit 0.
   function automatic lc3b_mem_wmask lane_mask(input logic byte_op, input logic addr_lsb);
      if (!byte_op) begin
         return WMASK_WORD;
      end
      return addr_lsb ? WMASK_HIGH : WMASK_LOW;
   endfunction

   // Zero-extend a byte to a full word.
   function automatic lc3b_word zext_byte(input logic [7:0] b);
      return {8'h00, b};
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Handshaked data-memory bus between the memory-access stage (master) and
// the data memory (slave). Strobes stay steady until the one-cycle resp.
interface mem_stage_if;

   logic [15:0] dmem_address;
   logic        dmem_read;
   logic        dmem_write;
   logic [1:0]  dmem_byte_enable;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_resp;

   modport master (
      output dmem_address,
      output dmem_read,
      output dmem_write,
      output dmem_byte_enable,
      output dmem_wdata,
      input  dmem_rdata,
      input  dmem_resp
   );

   modport slave (
      input  dmem_address,
      input  dmem_read,
      input  dmem_write,
      input  dmem_byte_enable,
      input  dmem_wdata,
      output dmem_rdata,
      output dmem_resp
   );

endinterface

// File: rtl/mem_stage_byte_align.sv
// Byte-lane steering for LDB/STB: produces the byte enable, the store data
// and the zero-extended load value. Purely combinational.
module mem_byte_align
   import lc3b_types::*;
(
   input  logic          byte_op,
   input  logic          addr_lsb,
   input  lc3b_word      sr2,
   input  lc3b_word      rdata,
   output lc3b_mem_wmask byte_enable,
   output lc3b_word      wdata,
   output lc3b_word      load_data
);

   genvar gi;

   // A byte store copies sr2[7:0] onto both lanes so whichever lane is
   // enabled carries the byte; a word store passes sr2 through unchanged.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         assign wdata[gi*8 +: 8] = byte_op ? sr2[7:0] : sr2[gi*8 +: 8];
      end
   endgenerate

   assign byte_enable = lane_mask(byte_op, addr_lsb);

   // Load extraction: whole word, or the addressed byte zero-extended.
   always_comb begin
      load_data = rdata;
      if (byte_op) begin
         load_data = zext_byte(addr_lsb ? rdata[15:8] : rdata[7:0]);
      end
   end

endmodule

// File: rtl/mem_stage.sv
// LC-3b pipeline memory-access stage. Sequences plain loads/stores, the
// two-access indirect LDI/STI and the TRAP vector read against a handshaked
// data memory, stalling the upstream pipeline until the access completes.
module mem_stage
   import lc3b_types::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              indirect,
   input  logic              byte_op,
   input  logic              trap,
   input  logic [ADDR_W-1:0] alu_out,
   input  logic [DATA_W-1:0] sr2,
   input  logic [ADDR_W-1:0] trap_vect8,
   mem_stage_if.master       dmem,
   output logic [DATA_W-1:0] mem_data,
   output logic              stall,
   output logic              done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_IND,
      ST_ACC,
      ST_DONE
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [DATA_W-1:0] ptr_reg;
   logic [DATA_W-1:0] ptr_next;
   logic [DATA_W-1:0] mem_data_reg;
   logic [DATA_W-1:0] mem_data_next;

   logic              op;
   logic              acc_is_read;
   logic              acc_is_write;
   logic              take_indirect;
   logic [ADDR_W-1:0] acc_addr;
   logic              align_byte_op;

   lc3b_mem_wmask     align_be;
   lc3b_word          align_wdata;
   lc3b_word          align_load;

   logic [ADDR_W-1:0] addr_sel;
   logic              rd_strobe;
   logic              wr_strobe;
   lc3b_mem_wmask     be_sel;

   // Operation decode. A read wins over a simultaneous write, and TRAP is
   // always a word read of the vector table regardless of the other flags.
   assign op            = valid_in & (mem_read | mem_write | trap);
   assign acc_is_read   = trap | mem_read;
   assign acc_is_write  = ~acc_is_read & mem_write;
   assign take_indirect = indirect & ~trap;
   assign align_byte_op = byte_op & ~trap;
   assign acc_addr      = trap ? trap_vect8 : (take_indirect ? ptr_reg : alu_out);

   mem_byte_align u_align (
      .byte_op     (align_byte_op),
      .addr_lsb    (acc_addr[0]),
      .sr2         (sr2),
      .rdata       (dmem.dmem_rdata),
      .byte_enable (align_be),
      .wdata       (align_wdata),
      .load_data   (align_load)
   );

   // State, pointer and load-result registers; reset abandons any access in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         ptr_reg      <= '0;
         mem_data_reg <= '0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         mem_data_reg <= mem_data_next;
      end
   end

   // Next-state and bus/pipeline control; resp outside IND/ACC is ignored.
   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      mem_data_next = mem_data_reg;
      addr_sel      = alu_out;
      rd_strobe     = 1'b0;
      wr_strobe     = 1'b0;
      be_sel        = WMASK_NONE;
      stall         = 1'b0;
      done          = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // Reset is asynchronous, so the stall it would otherwise raise
            // for a waiting op is masked while it is held.
            stall = op & ~reset;
            if (op) begin
               state_next = take_indirect ? ST_IND : ST_ACC;
            end
         end

         ST_IND: begin
            // Pointer fetch is always a full-word read at the EX address.
            stall     = 1'b1;
            rd_strobe = 1'b1;
            addr_sel  = alu_out;
            be_sel    = WMASK_WORD;
            if (dmem.dmem_resp) begin
               ptr_next   = dmem.dmem_rdata;
               state_next = ST_ACC;
            end
         end

         ST_ACC: begin
            stall     = 1'b1;
            rd_strobe = acc_is_read;
            wr_strobe = acc_is_write;
            addr_sel  = acc_addr;
            be_sel    = align_be;
            if (dmem.dmem_resp) begin
               if (acc_is_read) begin
                  mem_data_next = align_load;
               end
               state_next = ST_DONE;
            end
         end

         ST_DONE: begin
            // Upstream registers advance on this cycle.
            done       = 1'b1;
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign dmem.dmem_address     = addr_sel;
   assign dmem.dmem_read        = rd_strobe;
   assign dmem.dmem_write       = wr_strobe;
   assign dmem.dmem_byte_enable = be_sel;
   assign dmem.dmem_wdata       = align_wdata;

   assign mem_data = mem_data_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps followed by
// randomized loads/stores/traps, checked against a word-array reference model.
module tb_mem_stage;
   import lc3b_types::*;

   typedef struct packed {
      logic [15:0] addr;
      logic        wr;
      logic [1:0]  be;
      logic [15:0] wdata;
   } acc_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in, mem_read, mem_write, indirect, byte_op, trap;
   logic [15:0] alu_out, sr2, trap_vect8;
   logic [15:0] mem_data;
   logic        stall, done;

   mem_stage_if bus ();

   mem_stage #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .indirect   (indirect),
      .byte_op    (byte_op),
      .trap       (trap),
      .alu_out    (alu_out),
      .sr2        (sr2),
      .trap_vect8 (trap_vect8),
      .dmem       (bus),
      .mem_data   (mem_data),
      .stall      (stall),
      .done       (done)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] mem     [0:32767];
   logic [15:0] ref_mem [0:32767];
   int          delay_cfg   = 0;
   int          wait_cnt    = 0;
   logic        resp_auto   = 1'b0;
   logic        resp_manual = 1'b0;
   logic [15:0] rdata_drv   = 16'h0;
   acc_t        obs_q[$];
   acc_t        exp_q[$];
   logic [15:0] model_mem_data;
   int          exp_cycles;
   int          exp_strobe;
   logic        exp_store;
   logic [15:0] exp_store_addr;

   assign bus.dmem_rdata = rdata_drv;
   assign bus.dmem_resp  = resp_auto | resp_manual;

   function automatic acc_t mk_acc(input logic [15:0] a, input logic w, input logic [1:0] be,
                                   input logic [15:0] d);
      acc_t r;
      r.addr  = a;
      r.wr    = w;
      r.be    = be;
      r.wdata = d;
      return r;
   endfunction

   // Memory: answers an active strobe after delay_cfg wait cycles, writes by byte lane.
   always @(negedge clk) begin
      logic [15:0] w;
      resp_auto = 1'b0;
      rdata_drv = 16'($urandom);
      if (reset || !(bus.dmem_read || bus.dmem_write)) begin
         wait_cnt = 0;
      end else if (wait_cnt < delay_cfg) begin
         wait_cnt++;
      end else begin
         wait_cnt  = 0;
         resp_auto = 1'b1;
         obs_q.push_back(mk_acc(bus.dmem_address, bus.dmem_write, bus.dmem_byte_enable,
                                bus.dmem_wdata));
         w = mem[bus.dmem_address[15:1]];
         if (bus.dmem_read) begin
            rdata_drv = w;
         end else begin
            if (bus.dmem_byte_enable[0]) w[7:0]  = bus.dmem_wdata[7:0];
            if (bus.dmem_byte_enable[1]) w[15:8] = bus.dmem_wdata[15:8];
            mem[bus.dmem_address[15:1]] = w;
         end
      end
   end

   task automatic chk1(input string tag, input logic o, input logic e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] o, input logic [15:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic chk_int(input string tag, input int o, input int e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] v);
      mem[a[15:1]]     = v;
      ref_mem[a[15:1]] = v;
   endtask

   // Reference model: what the access list, latency and result must be.
   task automatic model_op(input logic rd, input logic wr, input logic ind, input logic bop,
                           input logic tr, input logic [15:0] a, input logic [15:0] s,
                           input logic [15:0] tv, input int d);
      logic [15:0] addr;
      logic [15:0] word;
      logic [7:0]  b;
      logic        is_byte;
      int          n_acc;
      exp_q.delete();
      exp_store = 1'b0;
      is_byte   = bop & ~tr;
      n_acc     = 1;
      addr      = tr ? tv : a;
      if (ind && !tr) begin
         exp_q.push_back(mk_acc(a, 1'b0, 2'b11, 16'h0));
         addr  = ref_mem[a[15:1]];
         n_acc = 2;
      end
      exp_cycles = 2 + n_acc + d * n_acc;
      exp_strobe = n_acc * (d + 1);
      word = ref_mem[addr[15:1]];
      if (tr || rd) begin
         exp_q.push_back(mk_acc(addr, 1'b0, is_byte ? (addr[0] ? 2'b10 : 2'b01) : 2'b11, 16'h0));
         if (is_byte) model_mem_data = addr[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
         else         model_mem_data = word;
      end else begin
         b = s[7:0];
         if (is_byte) begin
            if (addr[0]) word[15:8] = b;
            else         word[7:0]  = b;
            exp_q.push_back(mk_acc(addr, 1'b1, addr[0] ? 2'b10 : 2'b01, {b, b}));
         end else begin
            word = s;
            exp_q.push_back(mk_acc(addr, 1'b1, 2'b11, s));
         end
         ref_mem[addr[15:1]] = word;
         exp_store      = 1'b1;
         exp_store_addr = addr;
      end
   endtask

   // One instruction through the stage, checked cycle by cycle and at completion.
   task automatic run_op(input logic rd, input logic wr, input logic ind, input logic bop,
                         input logic tr, input logic [15:0] a, input logic [15:0] s,
                         input logic [15:0] tv, input int d, input logic drop, input string tag);
      int   cyc;
      int   stall_cyc;
      int   strobe_cyc;
      logic seen;
      logic stall_at_done;
      model_op(rd, wr, ind, bop, tr, a, s, tv, d);
      @(posedge clk);
      #1;
      obs_q.delete();
      delay_cfg  = d;
      valid_in   = 1'b1;
      mem_read   = rd;
      mem_write  = wr;
      indirect   = ind;
      byte_op    = bop;
      trap       = tr;
      alu_out    = a;
      sr2        = s;
      trap_vect8 = tv;
      cyc = 0; stall_cyc = 0; strobe_cyc = 0; seen = 1'b0; stall_at_done = 1'b1;
      while (!seen && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus.dmem_read || bus.dmem_write) strobe_cyc++;
         if (done) begin
            seen          = 1'b1;
            stall_at_done = stall;
         end else if (stall) begin
            stall_cyc++;
         end
         if (drop && cyc == 2) valid_in = 1'b0;
      end
      chk1({tag, "_done_seen"}, seen, 1'b1);
      chk_int({tag, "_cycles"}, cyc, exp_cycles);
      chk_int({tag, "_stall_cycles"}, stall_cyc, exp_cycles - 1);
      chk_int({tag, "_strobe_cycles"}, strobe_cyc, exp_strobe);
      chk1({tag, "_stall_at_done"}, stall_at_done, 1'b0);
      chk16({tag, "_mem_data"}, mem_data, model_mem_data);
      chk_int({tag, "_acc_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk16({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
         chk1({tag, "_wr"}, obs_q[i].wr, exp_q[i].wr);
         chk16({tag, "_be"}, {14'h0, obs_q[i].be}, {14'h0, exp_q[i].be});
         if (exp_q[i].wr) chk16({tag, "_wdata"}, obs_q[i].wdata, exp_q[i].wdata);
      end
      if (exp_store) begin
         chk16({tag, "_stored_word"}, mem[exp_store_addr[15:1]], ref_mem[exp_store_addr[15:1]]);
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      indirect = 1'b0; byte_op = 1'b0; trap = 1'b0;
      if (!seen) begin
         reset = 1'b1;
         #1;
         reset = 1'b0;
         model_mem_data = 16'h0;
      end
      @(negedge clk);
      chk1({tag, "_idle_done"}, done, 1'b0);
      chk1({tag, "_idle_stall"}, stall, 1'b0);
      chk1({tag, "_idle_strobe"}, bus.dmem_read | bus.dmem_write, 1'b0);
   endtask

   initial begin
      logic r_rd, r_wr, r_ind, r_bop, r_tr, r_drop;
      int   kind;

      reset = 1'b1;
      valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; indirect = 1'b0;
      byte_op = 1'b0; trap = 1'b1; alu_out = 16'h1234; sr2 = 16'h0; trap_vect8 = 16'h0020;
      model_mem_data = 16'h0;
      for (int i = 0; i < 32768; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end

      // Reset state, with an op already waiting at the input.
      @(negedge clk);
      @(negedge clk);
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_read", bus.dmem_read, 1'b0);
      chk1("rst_write", bus.dmem_write, 1'b0);
      chk16("rst_be", {14'h0, bus.dmem_byte_enable}, 16'h0);
      chk16("rst_mem_data", mem_data, 16'h0);
      valid_in = 1'b0; mem_read = 1'b0; trap = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // No memory op: valid alone, then an op flag without valid.
      valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("noop_stall", stall, 1'b0);
         chk1("noop_strobe", bus.dmem_read | bus.dmem_write, 1'b0);
         chk1("noop_done", done, 1'b0);
      end
      valid_in = 1'b0; mem_read = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("novalid_stall", stall, 1'b0);
         chk1("novalid_strobe", bus.dmem_read, 1'b0);
      end
      mem_read = 1'b0;

      // Stray resp in IDLE must not start or finish anything.
      @(posedge clk);
      #1;
      resp_manual = 1'b1;
      @(posedge clk);
      #1;
      resp_manual = 1'b0;
      @(negedge clk);
      chk1("idle_resp_done", done, 1'b0);
      chk16("idle_resp_mem_data", mem_data, 16'h0);

      // LDR
      preload(16'h3000, 16'hBEEF);
      run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0, 16'h0, 0, 1'b0, "ldr");
      chk16("ldr_value", mem_data, 16'hBEEF);

      // STB at an odd address
      run_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3001, 16'h00A5, 16'h0, 0, 1'b0, "stb");
      chk16("stb_mem_data_kept", mem_data, 16'hBEEF);
      chk16("stb_word", mem[16'h3000 >> 1], 16'hA5EF);

      // LDI
      preload(16'h4000, 16'h5002);
      preload(16'h5002, 16'h1234);
      run_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0, 16'h0, 0, 1'b0, "ldi");
      chk16("ldi_value", mem_data, 16'h1234);

      // TRAP vector read
      preload(16'h0040, 16'h1A00);
      run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h0, 16'h0040, 0, 1'b0, "trap");
      chk16("trap_value", mem_data, 16'h1A00);

      // LDB with wait states
      preload(16'h2000, 16'h80FF);
      run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2000, 16'h0, 16'h0, 5, 1'b0, "ldb_wait");
      chk16("ldb_wait_value", mem_data, 16'h00FF);

      // Randomized mix, including read+write, trap overrides and valid dropping mid-access.
      for (int n = 0; n < 40; n++) begin
         kind   = int'($urandom_range(0, 3));
         r_rd   = (kind == 0 || kind == 2);
         r_wr   = (kind == 1 || kind == 2);
         r_tr   = (kind == 3);
         if (r_tr) begin
            r_rd = 1'($urandom);
            r_wr = 1'($urandom);
         end
         r_ind  = 1'($urandom);
         r_bop  = 1'($urandom);
         r_drop = 1'($urandom);
         run_op(r_rd, r_wr, r_ind, r_bop, r_tr, 16'($urandom), 16'($urandom),
                16'($urandom_range(0, 255) << 1), int'($urandom_range(0, 3)), r_drop, "rand");
      end

      // Reset during ACC, then a late resp.
      preload(16'h6000, 16'h4321);
      @(posedge clk);
      #1;
      delay_cfg = 20;
      valid_in = 1'b1; mem_read = 1'b1; alu_out = 16'h6000;
      @(negedge clk);
      @(negedge clk);
      chk1("racc_read_before", bus.dmem_read, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk1("racc_read", bus.dmem_read, 1'b0);
      chk1("racc_write", bus.dmem_write, 1'b0);
      chk1("racc_stall", stall, 1'b0);
      chk16("racc_be", {14'h0, bus.dmem_byte_enable}, 16'h0);
      chk16("racc_mem_data", mem_data, 16'h0);
      model_mem_data = 16'h0;
      valid_in = 1'b0; mem_read = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      resp_manual = 1'b1;
      @(posedge clk);
      #1;
      resp_manual = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk1("racc_no_done", done, 1'b0);
         chk1("racc_idle_stall", stall, 1'b0);
         chk1("racc_idle_strobe", bus.dmem_read | bus.dmem_write, 1'b0);
      end
      chk16("racc_mem_data_after", mem_data, 16'h0);

      // Stage recovers normally afterwards.
      run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h6000, 16'h0, 16'h0, 1, 1'b0, "post_rst");
      chk16("post_rst_value", mem_data, 16'h4321);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage LC-3b pipeline. It sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Performs LDR/LDB/STR/STB, the indirect LDI/STI (two accesses) and the TRAP vector-table read against a handshaked data memory.
- Holds the pipeline through `stall` until each access completes, then presents the loaded word on `mem_data`.

Parameters:
- ADDR_W, 16, data-memory address width.
- DATA_W, 16, data word width (fixed by the ISA; a parameter only for package consistency).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  EX/MEM holds a live instruction
- mem_read  in  1  load-type op (LDR, LDB, LDI)
- mem_write  in  1  store-type op (STR, STB, STI)
- indirect  in  1  LDI/STI: first read fetches the pointer
- byte_op  in  1  LDB/STB
- trap  in  1  TRAP: read vector table
- alu_out  in  16  effective address from EX
- sr2  in  16  store data
- trap_vect8  in  16  zext(trapvect8)<<1
- dmem_address  out  16  memory address
- dmem_read  out  1  read strobe
- dmem_write  out  1  write strobe
- dmem_byte_enable  out  2  byte lanes, bit1 = high byte
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data, valid with resp
- dmem_resp  in  1  one-cycle completion pulse
- mem_data  out  16  load/trap result to MEM/WB
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- done  out  1  one-cycle pulse: access finished

Behaviour:
- **Reset.** `reset` is asynchronous and active-high; `clk` is the single clock.
  - Reset forces state IDLE, the pointer register to 0 and `mem_data` to 0.
  - While `reset` is high, `dmem_read`, `dmem_write`, `stall` and `done` are 0 and `dmem_byte_enable` is 00.
  - Reset mid-access abandons the access. A late `dmem_resp` after reset is ignored.
- **Definitions.**
  - op = valid_in & (mem_read | mem_write | trap).
  - mem_read & mem_write together is treated as a read; the write is ignored.
  - trap overrides both.
- **States.**
  - IDLE:
    - op & (indirect & ~trap) → IND.
    - op otherwise → ACC.
    - no op → IDLE, `stall` = 0.
  - IND:
    - `dmem_read` = 1, address = `alu_out`, byte enable = 11.
    - On `dmem_resp`: latch `dmem_rdata` into ptr, go to ACC.
  - ACC:
    - address = trap ? `trap_vect8` : indirect ? ptr : `alu_out`.
    - Asserts `dmem_read` or `dmem_write`.
    - On `dmem_resp`: for a read, latch the result into `mem_data`; go to DONE.
  - DONE: `done` = 1, `stall` = 0; unconditionally → IDLE. Upstream advances on this cycle.
- **Stall rule.** `stall` = 1 in IDLE when op is present, and in IND and ACC. `stall` = 0 in DONE.
- **Strobe rule.** Strobes are asserted only in IND/ACC and are held steady until `dmem_resp`.
- **Latency** (memory answering the cycle after the request):
  - Plain access: 3 cycles (IDLE, ACC, DONE).
  - Indirect access: 4 cycles.
  - Slower memory adds 1 cycle per wait.
- **Byte handling** (ACC only; IND is always a word read):
  - Byte enable = byte_op ? (addr[0] ? 10 : 01) : 11.
  - Byte store: `dmem_wdata` = {sr2[7:0], sr2[7:0]}.
  - Word store: `dmem_wdata` = `sr2`.
  - Byte load: `mem_data` = zext(addr[0] ? rdata[15:8] : rdata[7:0]).
  - Word load: `mem_data` = rdata. Word addresses are driven as-is; memory ignores bit 0.
- **mem_data.** Holds its value until the next completed read. Stores and non-memory ops leave it unchanged.
- **Boundaries.**
  - `dmem_resp` in IDLE or DONE is ignored.
  - `valid_in` dropping mid-access does not abort the access; only reset aborts.
  - Address arithmetic wraps at 16 bits.

Decomposition:
- lc3b_types package: lc3b_word and the byte-enable type lc3b_mem_wmask (2 bits).
- The mem_stage state enum stays local to the module.
- One natural combinational sub-module, mem_byte_align, which produces the byte enable, the write data and the load extraction from byte_op, addr[0], sr2 and rdata.

Test Plan:
1. **LDR.** alu_out=0x3000, mem_read, rdata=0xBEEF with resp 1 cycle after request → dmem_read for 1 cycle at 0x3000, mem_data=0xBEEF, done on cycle 3, stall high cycles 1–2.
2. **STB, odd address.** alu_out=0x3001, sr2=0x00A5, byte_op → byte_enable=10, wdata=0xA5A5, dmem_write until resp, mem_data unchanged.
3. **LDI.** alu_out=0x4000, mem[0x4000]=0x5002, mem[0x5002]=0x1234 → first read at 0x4000, then at 0x5002, mem_data=0x1234, 4-cycle latency.
4. **TRAP.** trap_vect8=0x0040, mem[0x0040]=0x1A00 → read at 0x0040, mem_data=0x1A00.
5. **Wait states.** resp delayed 5 cycles on an LDB at 0x2000 with rdata=0x80FF → stall held throughout, mem_data=0x00FF.
6. **Reset in ACC.** Reset asserted during ACC, then resp arrives → strobes drop immediately, state IDLE, mem_data=0, no done pulse.
